// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and divider rounding
//
// Purpose: receiver FSM state encoding, frame width and the clock-divider
// rounding helper used by both the receiver tick generator and the
// transmitter baud generator.
// Ports: none (package).

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per tick, rounded to nearest and never below one so that a
    // too-fast rate still yields a working (every-cycle) tick.
    function automatic int div_round(input int clk_hz, input int rate);
        int q;
        q = (clk_hz + rate / 2) / rate;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - free-running oversample tick divider
//
// Purpose: emits a one-clock tick every DIV clocks.
// Ports:
//   clk   - system clock
//   reset - synchronous active-low reset; counter returns to 0
//   tick  - high for one clock when the counter is at DIV-1

module uart_rx_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // With DIV == 1 the counter stays at 0 and tick is permanently high.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit majority voting
//
// Purpose: synchronises and oversamples serial_rx, votes three samples
// around each bit centre, and holds completed bytes until read.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-low reset
//   serial_rx   - asynchronous serial line, idle high
//   rx_read     - one-cycle pulse consuming the held byte
//   data_out    - last received byte
//   rx_valid    - data_out holds an unread byte
//   frame_error - one-cycle pulse when the stop bit votes low
//   overrun     - one-cycle pulse when an unread byte is overwritten
//   busy        - receiver is inside a frame

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = div_round(CLK_HZ, BAUD * OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SC_V0   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_V1   = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SC_DEC  = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [IW-1:0]  BIT_LAST = IW'(DATA_BITS - 1);

    logic tick;
    logic rx_meta;
    logic rx_s;

    rx_state_t            state, state_next;
    logic [SCW-1:0]       sc, sc_next;
    logic [IW-1:0]        bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [1:0]           votes, votes_next;
    logic                 armed, armed_next;
    logic                 byte_done, byte_done_next;
    logic                 ferr_next;
    logic                 decide;
    logic                 majority;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchroniser; reset high so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_rx;
            rx_s    <= rx_meta;
        end
    end

    // The third vote is the live synchronised sample at the decision tick.
    assign decide   = tick && (sc == SC_DEC);
    assign majority = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

    always_comb begin
        state_next     = state;
        sc_next        = sc;
        bit_idx_next   = bit_idx;
        shreg_next     = shreg;
        votes_next     = votes;
        armed_next     = armed;
        byte_done_next = 1'b0;
        ferr_next      = 1'b0;

        // A break (line held low) must see the line high again before the
        // next falling edge can start a frame.
        if (tick && rx_s) begin
            armed_next = 1'b1;
        end

        if (tick && (state != IDLE)) begin
            if (sc == SC_V0) begin
                votes_next[0] = rx_s;
            end
            if (sc == SC_V1) begin
                votes_next[1] = rx_s;
            end
            sc_next = (sc == SC_LAST) ? '0 : sc + 1'b1;
        end

        case (state)
            IDLE: begin
                if (tick && !rx_s && armed) begin
                    state_next = START;
                    sc_next    = '0;
                end
            end
            START: begin
                if (decide) begin
                    if (!majority) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        // Too short to be a start bit: drop it silently.
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_next   = {majority, shreg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit gives half a bit of slack before
                // the next start edge.
                if (decide) begin
                    state_next = IDLE;
                    if (majority) begin
                        byte_done_next = 1'b1;
                    end else begin
                        ferr_next  = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sc        <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            votes     <= '0;
            armed     <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            state     <= state_next;
            sc        <= sc_next;
            bit_idx   <= bit_idx_next;
            shreg     <= shreg_next;
            votes     <= votes_next;
            armed     <= armed_next;
            byte_done <= byte_done_next;
        end
    end

    // Holding register. A completion in the same cycle as a read wins, so
    // the fresh byte stays valid and no overrun is reported.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out    <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= ferr_next;
            overrun     <= 1'b0;
            if (byte_done) begin
                data_out <= shreg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_read;
            end else if (rx_read && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
